// File: rtl/vram_arbiter_if.sv
// Arbiter-facing bundle: CPU store channel, scanout read channel, fill command and the VRAM port.
// master = requesters plus VRAM model side, slave = the arbiter.
interface vram_arbiter_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32
);
  logic              cpu_wvalid;
  logic              cpu_wready;
  logic [ADDR_W-1:0] cpu_waddr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              scan_req;
  logic [ADDR_W-1:0] scan_addr;
  logic              scan_ack;
  logic [DATA_W-1:0] scan_rdata;
  logic              fill_start;
  logic [DATA_W-1:0] fill_value;
  logic              fill_busy;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output cpu_wvalid, cpu_waddr, cpu_wdata, scan_req, scan_addr,
           fill_start, fill_value, mem_rdata,
    input  cpu_wready, scan_ack, scan_rdata, fill_busy,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  cpu_wvalid, cpu_waddr, cpu_wdata, scan_req, scan_addr,
           fill_start, fill_value, mem_rdata,
    output cpu_wready, scan_ack, scan_rdata, fill_busy,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: scan read > CPU FIFO pop / fill write; scan data 1 cycle after grant.
// CPU backpressure via cpu_wready (FIFO full or fill pending); fill engine present only with VRAM_ARB_FILL_EN.
module vram_arbiter #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32
) (
  input logic          clk,
  input logic          rst,
  vram_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, DRAIN, FILL} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] fifo_addr [2];
  logic [DATA_W-1:0] fifo_data [2];
  logic              wr_ptr, rd_ptr;
  logic [1:0]        count;
  logic              rd_pend;
  logic              full, empty, scan_grant, push, pop, fill_wr;
  logic [ADDR_W-1:0] fill_addr;
  logic [DATA_W-1:0] fill_dat;

  assign full  = (count == 2'd2);
  assign empty = (count == 2'd0);

  // Grants are gated by rst so the port stays quiet while reset is held.
  assign scan_grant     = rst && bus.scan_req && !rd_pend;
  assign bus.cpu_wready = rst && !full && (state == IDLE);
  assign push           = bus.cpu_wvalid && bus.cpu_wready;
  assign pop            = !scan_grant && !empty && (state != FILL);

  assign bus.scan_ack   = rd_pend;
  assign bus.scan_rdata = bus.mem_rdata;
  assign bus.fill_busy  = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      count   <= 2'd0;
      rd_pend <= 1'b0;
      state   <= IDLE;
    end else begin
      if (push) wr_ptr <= !wr_ptr;
      if (pop)  rd_ptr <= !rd_ptr;
      count   <= count + {1'b0, push} - {1'b0, pop};
      rd_pend <= scan_grant;
      state   <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= bus.cpu_waddr;
      fifo_data[wr_ptr] <= bus.cpu_wdata;
    end
  end

`ifdef VRAM_ARB_FILL_EN
  logic [ADDR_W-1:0] cnt, cnt_nxt;
  logic [DATA_W-1:0] fill_val;

  assign fill_wr   = (state == FILL) && !scan_grant;
  assign fill_addr = cnt;
  assign fill_dat  = fill_val;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        // A store accepted alongside fill_start is already queued, so it must drain first.
        if (bus.fill_start) state_nxt = (empty && !push) ? FILL : DRAIN;
      end
      DRAIN: begin
        if (empty) state_nxt = FILL;
      end
      FILL: begin
        if (fill_wr) begin
          if (&cnt) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt      <= '0;
      fill_val <= '0;
    end else begin
      cnt <= cnt_nxt;
      if (state == IDLE && bus.fill_start) fill_val <= bus.fill_value;
    end
  end
`else
  logic unused_fill;
  assign unused_fill = ^{bus.fill_start, bus.fill_value};
  assign fill_wr     = 1'b0;
  assign fill_addr   = '0;
  assign fill_dat    = '0;
  assign state_nxt   = IDLE;
`endif

  always_comb begin
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (scan_grant) begin
      bus.mem_en   = 1'b1;
      bus.mem_addr = bus.scan_addr;
    end else if (pop) begin
      bus.mem_en    = 1'b1;
      bus.mem_we    = 1'b1;
      bus.mem_addr  = fifo_addr[rd_ptr];
      bus.mem_wdata = fifo_data[rd_ptr];
    end else if (fill_wr) begin
      bus.mem_en    = 1'b1;
      bus.mem_we    = 1'b1;
      bus.mem_addr  = fill_addr;
      bus.mem_wdata = fill_dat;
    end
  end
endmodule
